cpu_mem_responder: RTL

Memory-side responder for the CPU's instruction and data ports: a single-clock, word-organised RAM with a registered instruction read port and a registered data read/write port, plus a memory-mapped console byte FIFO. It sits between the CPU core and the top level and answers every fetch, load and store the core issues. Stores arrive as full 32-bit words because the core merges bytes and halfwords itself.

---
 rtl/cpu_mem_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// cpu_mem_responder
//
// Memory-side responder for the CPU core. It provides a word-organised RAM
// with two registered ports and an optional memory-mapped console byte FIFO.
//   - Instruction port: reads every cycle and returns the word one cycle later.
//   - Data port: loads and stores, qualified by a one-cycle strobe. Load data
//     stays on data_o until the next load strobe.
//   - Console (only when MEM_CONSOLE_EN is defined): a store to CONSOLE_ADDR
//     pushes a byte into a small FIFO. A load from CONSOLE_ADDR returns
//     {29'b0, overflow, full, empty}. The FIFO drains through a valid/ready
//     pair.
//
// Parameters:
//   MEM_WORDS    RAM depth in 32-bit words
//   BASE_ADDR    byte address of RAM word 0
//   CONSOLE_ADDR byte address of the console register
//   FIFO_DEPTH   console FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   iaddr_i / idata_o   instruction fetch address / registered instruction
//   addr_i, wdata_i     data byte address / full-word store data
//   wr_i                store qualifier (only meaningful with the strobe)
//   data_addr_strobe_i  one-cycle data access request
//   data_o              registered, held load data
//   con_data_o          byte at the head of the console FIFO
//   con_valid_o         console FIFO non-empty
//   con_ready_i         consumer takes the head byte
//   fault_o             sticky out-of-range access flag
//
// Configuration macro: MEM_CONSOLE_EN. When it is undefined the FIFO is
// removed and CONSOLE_ADDR is decoded as an ordinary address.
// -----------------------------------------------------------------------------
module cpu_mem_responder #(
  parameter int          MEM_WORDS    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] CONSOLE_ADDR = 32'hFFFF_FFF0,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iaddr_i,
  output logic [31:0] idata_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        wr_i,
  input  logic        data_addr_strobe_i,
  output logic [31:0] data_o,
  output logic [7:0]  con_data_o,
  output logic        con_valid_o,
  input  logic        con_ready_i,
  output logic        fault_o
);

  localparam int          MW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic [31:0] mem [MEM_WORDS];

  // Word offsets relative to the RAM base. An address below the base wraps
  // to a huge offset, so it falls out of range on its own.
  logic [31:0]   ioff;
  logic [31:0]   doff;
  logic          i_in_range;
  logic          d_in_range;
  logic [MW-1:0] i_idx;
  logic [MW-1:0] d_idx;

  assign ioff       = iaddr_i - BASE_ADDR;
  assign doff       = addr_i - BASE_ADDR;
  assign i_in_range = (ioff[31:2] < MEM_LIMIT);
  assign d_in_range = (doff[31:2] < MEM_LIMIT);
  assign i_idx      = ioff[MW+1:2];
  assign d_idx      = doff[MW+1:2];

  // Decoded data-port requests. Console accesses never touch the RAM and
  // never raise a fault.
  logic        con_sel;
  logic [31:0] con_status;
  logic        ram_rd;
  logic        ram_wr;
  logic        d_fault;

  assign ram_rd  = data_addr_strobe_i & ~wr_i & ~con_sel;
  assign ram_wr  = data_addr_strobe_i &  wr_i & ~con_sel & d_in_range;
  assign d_fault = data_addr_strobe_i & ~con_sel & ~d_in_range;

  // RAM write port. There is no reset, so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem[d_idx] <= wdata_i;
    end
  end

  // Registered read ports and the sticky fault flag. The instruction read
  // samples the array before this edge's write lands, which gives the
  // read-before-write behaviour on a same-word conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idata_o <= NOP;
      data_o  <= 32'h0;
      fault_o <= 1'b0;
    end else begin
      idata_o <= i_in_range ? mem[i_idx] : NOP;

      if (data_addr_strobe_i && !wr_i) begin
        if (con_sel) begin
          data_o <= con_status;
        end else if (ram_rd && d_in_range) begin
          data_o <= mem[d_idx];
        end else begin
          data_o <= 32'h0;
        end
      end

      if (!i_in_range || d_fault) begin
        fault_o <= 1'b1;
      end
    end
  end

`ifdef MEM_CONSOLE_EN
  // ---------------------------------------------------------------------------
  // Console byte FIFO. The pointers carry one extra MSB so that full and
  // empty can be told apart without a separate count.
  // ---------------------------------------------------------------------------
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        overflow;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        do_push;

  assign con_sel = (addr_i[31:2] == CONSOLE_ADDR[31:2]);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign pop     = ~empty & con_ready_i;
  assign push    = data_addr_strobe_i & wr_i & con_sel;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then; it lands in the slot being vacated.
  assign do_push = push & (~full | pop);

  assign con_status  = {29'h0, overflow, full, empty};
  assign con_valid_o = ~empty;
  assign con_data_o  = empty ? 8'h00 : fifo_mem[rd_ptr[AW-1:0]];

  // Pointer and overflow state; asynchronous reset flushes the FIFO at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // FIFO storage; gated by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= wdata_i[7:0];
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, ioff[1:0], doff[1:0]};
`else
  // Console removed: no special decode, outputs tied low.
  assign con_sel     = 1'b0;
  assign con_status  = 32'h0;
  assign con_valid_o = 1'b0;
  assign con_data_o  = 8'h00;

  logic unused_bits;
  assign unused_bits = &{1'b0, ioff[1:0], doff[1:0], con_ready_i};
`endif

endmodule
